rfid_wb_arbiter: RTL and testbench
==================================

Name: rfid_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the single 8-bit Wishbone bus of the SPI master and its peripherals. Requester 0 is the RFID state controller; requester 1 is a second sequencer, such as the sample readout engine or the host debug port. The block grants the bus round-robin and holds the grant for a whole cycle. A watchdog aborts any cycle that is never acknowledged, so a hung slave cannot lock out the other master.

Parameters:
TIMEOUT_CYCLES, 255, number of granted cycles without ack_i before abort; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  Wishbone clock
rst_i  in  1  synchronous reset, active-high
m0_cyc_i  in  1  master 0 cycle request
m0_stb_i  in  2  master 0 strobe/chip-select
m0_adr_i  in  3  master 0 register address
m0_we_i  in  1  master 0 write enable
m0_dat_i  in  8  master 0 write data
m0_dat_o  out  8  read data to master 0
m0_ack_o  out  1  acknowledge to master 0
m0_err_o  out  1  timeout abort pulse to master 0
m1_cyc_i, m1_stb_i, m1_adr_i, m1_we_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0_*  master 1 equivalents
cyc_o  out  1  shared bus cycle
stb_o  out  2  shared bus strobe
adr_o  out  3  shared bus address
we_o  out  1  shared bus write enable
dat_o  out  8  shared bus write data
dat_i  in  8  shared bus read data
ack_i  in  1  shared bus acknowledge
grant_o  out  2  one-hot current grant (bit n = master n); 00 when idle
timeout_cnt_o  out  8  saturating count of watchdog aborts since reset

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. Registers: state, last (last master served), wd counter, abort owner, timeout_cnt.
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, last=1 (master 0 wins the first tie), wd=0, timeout_cnt=0.
  - All bus outputs, acks, errs and grant_o are 0 from the following cycle.
  - Reset mid-cycle drops cyc_o immediately. No ack or err is delivered for the abandoned cycle.
- IDLE:
  - Shared bus outputs are all 0.
  - If exactly one mN_cyc_i=1, go to GNTN.
  - If both are 1, go to GNT(1-last).
  - Grant latency is one clock from the request edge.
- GNTn:
  - cyc_o, stb_o, adr_o, we_o and dat_o are combinational copies of master n's inputs, with stb_o ANDed with the master's cyc.
  - mn_ack_o = ack_i. m(1-n)_ack_o = 0.
  - last <= n on entry.
  - When mn_cyc_i=0, go to IDLE. Re-arbitration happens in IDLE on the next cycle, so a master that drops cyc for one cycle between transfers yields to a pending rival.
- Read data: m0_dat_o and m1_dat_o both equal dat_i at all times. Only the ack is steered.
- Watchdog, in GNTn when TIMEOUT_CYCLES≠0:
  - wd increments each cycle that cyc_o=1 and ack_i=0.
  - wd clears on ack_i=1 and on leaving GNTn.
  - When wd reaches TIMEOUT_CYCLES with ack_i still 0, go to ABORT. mn_err_o is 1 for exactly one cycle (the first ABORT cycle) and cyc_o is 0 from that cycle on.
  - timeout_cnt increments and saturates at 255.
- Simultaneous ack_i and timeout on the same cycle: the ack wins. It is delivered, wd clears and no abort occurs.
- ABORT:
  - Bus outputs are 0 and acks are 0.
  - Stay until the aborted master's cyc is 0, then go to IDLE.
  - last keeps the aborted master, so a waiting rival is granted next.
- ack_i arriving in IDLE or ABORT is ignored and not forwarded.
- grant_o is registered from state: 01 in GNT0, 10 in GNT1, 00 otherwise.

Test Plan:
- Single master: m0 writes adr=2, dat=0x0A, we=1 and the slave acks 3 cycles later → cyc_o rises 1 clk after m0_cyc_i, adr_o=2, dat_o=0x0A, m0_ack_o pulses once, m1_ack_o stays 0.
- Tie after reset: m0 and m1 assert cyc on the same clk → GNT0 first (grant_o=01). After m0 drops cyc, GNT1 (grant_o=10). A repeated tie then goes to m0.
- Fairness: m0 requests back-to-back (cyc low for 1 clk between transfers) while m1 is continuously requesting → grants alternate 0,1,0,1 over 8 transfers.
- Timeout: TIMEOUT_CYCLES=4, m1 granted, ack_i held 0 → after 4 granted cycles m1_err_o pulses for 1 clk, cyc_o=0, timeout_cnt_o=1; a pending m0 is granted only after m1 drops cyc.
- Ack/timeout collision: ack_i=1 exactly on the TIMEOUT_CYCLES-th cycle → m0_ack_o=1, no err, timeout_cnt_o unchanged.
- Reset mid-cycle: rst_i=1 while in GNT0 with ack pending → next cycle cyc_o=0, grant_o=00, no ack or err. After release, a tie is granted to m0.

Source files
------------

// File: rtl/rfid_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared 8-bit SPI/peripheral bus.
// The grant is held for a whole cycle. A watchdog aborts cycles that are never acknowledged.
module rfid_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic [1:0] m0_stb_i,
  input  logic [2:0] m0_adr_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic [1:0] m1_stb_i,
  input  logic [2:0] m1_adr_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       cyc_o,
  output logic [1:0] stb_o,
  output logic [2:0] adr_o,
  output logic       we_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  output logic [1:0] grant_o,
  output logic [7:0] timeout_cnt_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t           state, state_nxt;
  logic             last, abort_owner, err_q;
  logic [CNT_W-1:0] wd;
  logic [7:0]       timeout_cnt;
  logic             granted, owner_cyc, abort_cyc, timeout_hit;

  assign granted   = (state == GNT0) || (state == GNT1);
  assign owner_cyc = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
  assign abort_cyc = abort_owner ? m1_cyc_i : m0_cyc_i;

  // Abort on the TIMEOUT_CYCLES-th unacked granted cycle; an ack on that same cycle wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && granted && owner_cyc && !ack_i &&
                       (wd == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last        <= 1'b1;
      wd          <= '0;
      abort_owner <= 1'b0;
      err_q       <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state <= state_nxt;
      err_q <= timeout_hit;
      if (state == IDLE && state_nxt == GNT0) last <= 1'b0;
      if (state == IDLE && state_nxt == GNT1) last <= 1'b1;
      if (!granted || state_nxt != state || ack_i || TIMEOUT_CYCLES == 0) wd <= '0;
      else if (owner_cyc) wd <= wd + CNT_W'(1);
      if (timeout_hit) begin
        abort_owner <= (state == GNT1);
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!owner_cyc)       state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ABORT;
      end
      ABORT:   if (!abort_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cyc_o    = 1'b0;
    stb_o    = '0;
    adr_o    = '0;
    we_o     = 1'b0;
    dat_o    = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      GNT0: begin
        cyc_o    = m0_cyc_i;
        stb_o    = m0_stb_i & {2{m0_cyc_i}};
        adr_o    = m0_adr_i;
        we_o     = m0_we_i;
        dat_o    = m0_dat_i;
        m0_ack_o = ack_i;
        grant_o  = 2'b01;
      end
      GNT1: begin
        cyc_o    = m1_cyc_i;
        stb_o    = m1_stb_i & {2{m1_cyc_i}};
        adr_o    = m1_adr_i;
        we_o     = m1_we_i;
        dat_o    = m1_dat_i;
        m1_ack_o = ack_i;
        grant_o  = 2'b10;
      end
      ABORT: begin
        m0_err_o = err_q && !abort_owner;
        m1_err_o = err_q && abort_owner;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the ack is steered to the owner.
  assign m0_dat_o      = dat_i;
  assign m1_dat_o      = dat_i;
  assign timeout_cnt_o = timeout_cnt;
endmodule

// File: tb/tb_rfid_wb_arbiter.sv
// Bench for rfid_wb_arbiter: directed vector table, fairness sequence, and random traffic
// checked against a transaction-level model of ownership, timeouts and abort counting.
module tb_rfid_wb_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_cyc, m1_cyc, m0_we, m1_we, ack_i;
  logic [1:0] m0_stb, m1_stb;
  logic [2:0] m0_adr, m1_adr;
  logic [7:0] m0_dat, m1_dat, dat_i;
  logic [7:0] m0_rd, m1_rd, dat_o, tcnt;
  logic       m0_ack, m1_ack, m0_err, m1_err, cyc_o, we_o;
  logic [1:0] stb_o, grant;
  logic [2:0] adr_o;

  int n_cmp = 0;
  int n_bad = 0;

  rfid_wb_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_we_i(m0_we),
    .m0_dat_i(m0_dat), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_we_i(m1_we),
    .m1_dat_i(m1_dat), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .grant_o(grant), .timeout_cnt_o(tcnt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long it has waited unacked, abort bookkeeping.
  int md_owner  = -1;
  int md_abort  = 0;
  int md_who    = 0;
  int md_err    = 0;
  int md_last   = 1;
  int md_silent = 0;
  int md_aborts = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_advance();
    logic [1:0] c;
    c = {m1_cyc, m0_cyc};
    if (rst) begin
      md_owner = -1; md_abort = 0; md_err = 0; md_last = 1; md_silent = 0; md_aborts = 0;
    end else if (md_abort != 0) begin
      md_err = 0;
      if (!c[md_who]) md_abort = 0;
    end else if (md_owner < 0) begin
      if (c == 2'b11)  md_owner = 1 - md_last;
      else if (c[0])   md_owner = 0;
      else if (c[1])   md_owner = 1;
      if (md_owner >= 0) md_last = md_owner;
      md_silent = 0;
    end else if (!c[md_owner]) begin
      md_owner  = -1;
      md_silent = 0;
    end else if (ack_i) begin
      md_silent = 0;
    end else begin
      md_silent++;
      if (md_silent == TO) begin
        md_abort = 1; md_who = md_owner; md_err = 1; md_owner = -1; md_silent = 0;
        if (md_aborts < 255) md_aborts++;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [14:0] eb;
    logic [1:0]  ea, ee, eg;
    eb = '0; ea = '0; ee = '0; eg = '0;
    if (md_owner == 0) begin
      eb = {m0_cyc, m0_stb & {2{m0_cyc}}, m0_adr, m0_we, m0_dat};
      ea = {1'b0, ack_i};
      eg = 2'b01;
    end else if (md_owner == 1) begin
      eb = {m1_cyc, m1_stb & {2{m1_cyc}}, m1_adr, m1_we, m1_dat};
      ea = {ack_i, 1'b0};
      eg = 2'b10;
    end
    if (md_abort != 0 && md_err != 0) ee = (md_who == 1) ? 2'b10 : 2'b01;
    cmp({tag, ".bus"}, {cyc_o, stb_o, adr_o, we_o, dat_o}, eb);
    cmp({tag, ".resp"}, {m1_ack, m0_ack, m1_err, m0_err, m1_rd, m0_rd}, {ea, ee, dat_i, dat_i});
    cmp({tag, ".stat"}, {grant, tcnt}, {eg, 8'(md_aborts)});
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst;
    logic [1:0] cyc;
    logic       ack;
    logic [1:0] g;
    logic       c;
    logic [1:0] a;
    logic [1:0] e;
    logic [7:0] t;
  } vec_t;

  vec_t tbl [64];
  int   ntbl = 0;

  function automatic void add(input logic r, input logic [1:0] cy, input logic ak,
                              input logic [1:0] g, input logic c, input logic [1:0] a,
                              input logic [1:0] e, input logic [7:0] t);
    tbl[ntbl] = '{r, cy, ak, g, c, a, e, t};
    ntbl++;
  endfunction

  initial begin
    logic [1:0] mc, nmc;
    int seq [8];
    int nx;

    rst = 1'b1; m0_cyc = 1'b0; m1_cyc = 1'b0; ack_i = 1'b0; dat_i = 8'hC3;
    m0_stb = 2'b01; m0_adr = 3'd2; m0_we = 1'b1; m0_dat = 8'h0A;
    m1_stb = 2'b10; m1_adr = 3'd5; m1_we = 1'b0; m1_dat = 8'h55;

    //   rst cyc   ack grant cyc ack   err   tcnt
    // tie after reset, then m1, then repeated tie back to m0
    add(0, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 2'b01, 1, 2'b01, 2'b00, 0);
    add(0, 2'b10, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    add(0, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b10, 1, 2'b10, 1, 2'b10, 2'b00, 0);
    add(0, 2'b00, 0, 2'b10, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    add(0, 2'b01, 1, 2'b01, 1, 2'b01, 2'b00, 0);
    add(0, 2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    // single master write, slave acks 3 cycles after the request; late ack in IDLE ignored
    add(0, 2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    add(0, 2'b01, 1, 2'b01, 1, 2'b01, 2'b00, 0);
    add(0, 2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0);
    add(0, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    // m1 times out after 4 granted cycles; m0 waits until m1 drops cyc
    add(0, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b10, 1, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b10, 1);
    add(0, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    add(0, 2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    add(0, 2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 1);
    // ack lands on the 4th granted cycle: ack wins, no abort
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    add(0, 2'b01, 1, 2'b01, 1, 2'b01, 2'b00, 1);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    add(0, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    // reset in the middle of a granted cycle, then a tie goes to m0
    add(1, 2'b01, 0, 2'b01, 1, 2'b00, 2'b00, 1);
    add(0, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 2'b01, 1, 2'b00, 2'b00, 0);
    add(0, 2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0);

    #1;
    step();
    #4;
    cmp("reset.bus", {cyc_o, stb_o, adr_o, we_o, dat_o}, 15'd0);
    cmp("reset.resp", {m1_ack, m0_ack, m1_err, m0_err}, 4'd0);
    cmp("reset.stat", {grant, tcnt}, 10'd0);
    cmp("reset.rdata", {m1_rd, m0_rd}, 16'hC3C3);
    step();

    for (int i = 0; i < ntbl; i++) begin
      rst = tbl[i].rst; m0_cyc = tbl[i].cyc[0]; m1_cyc = tbl[i].cyc[1]; ack_i = tbl[i].ack;
      #4;
      cmp($sformatf("vec%0d.grant", i), grant, tbl[i].g);
      cmp($sformatf("vec%0d.cyc", i), cyc_o, tbl[i].c);
      cmp($sformatf("vec%0d.ack", i), {m1_ack, m0_ack}, tbl[i].a);
      cmp($sformatf("vec%0d.err", i), {m1_err, m0_err}, tbl[i].e);
      cmp($sformatf("vec%0d.tcnt", i), tcnt, tbl[i].t);
      if (tbl[i].g == 2'b01)
        cmp($sformatf("vec%0d.m0bus", i), {stb_o, adr_o, we_o, dat_o},
            {1'b0, tbl[i].cyc[0], 3'd2, 1'b1, 8'h0A});
      else if (tbl[i].g == 2'b10)
        cmp($sformatf("vec%0d.m1bus", i), {stb_o, adr_o, we_o, dat_o},
            {tbl[i].cyc[1], 1'b0, 3'd5, 1'b0, 8'h55});
      else
        cmp($sformatf("vec%0d.idlebus", i), {stb_o, adr_o, we_o, dat_o}, 14'd0);
      step();
    end

    // Fairness: both masters keep requesting, each drops cyc for one clock after its ack.
    rst = 1'b1; m0_cyc = 1'b0; m1_cyc = 1'b0; ack_i = 1'b0;
    step();
    rst = 1'b0;
    mc = 2'b11;
    nx = 0;
    for (int cy = 0; cy < 200 && nx < 8; cy++) begin
      m0_cyc = mc[0]; m1_cyc = mc[1];
      ack_i  = (grant != 2'b00);
      #4;
      model_check("fair");
      nmc = 2'b11;
      if (m0_cyc && m0_ack && nx < 8) begin seq[nx] = 0; nx++; nmc[0] = 1'b0; end
      if (m1_cyc && m1_ack && nx < 8) begin seq[nx] = 1; nx++; nmc[1] = 1'b0; end
      mc = nmc;
      step();
    end
    cmp("fair.transfers", nx, 8);
    for (int i = 0; i < nx; i++) cmp($sformatf("fair.grant%0d", i), seq[i], i % 2);

    // Random traffic with sticky requests so hung cycles and timeouts occur regularly.
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 5) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 2'($urandom); m0_adr = 3'($urandom); m0_we = 1'($urandom); m0_dat = 8'($urandom);
      m1_stb = 2'($urandom); m1_adr = 3'($urandom); m1_we = 1'($urandom); m1_dat = 8'($urandom);
      dat_i  = 8'($urandom);
      ack_i  = ($urandom_range(0, 3) == 0);
      #4;
      model_check("rnd");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
